// File: rtl/clb_pkg.sv
// Shared types and constants for the CLB column context sequencer.
package clb_pkg;

  localparam int unsigned NUM_CELLS  = 4;
  localparam int unsigned CELL_CFG_W = 9;
  localparam int unsigned COL_CFG_W  = 36;

  localparam int unsigned BYP_OFS  = 8;
  localparam int unsigned SEL0_OFS = 5;
  localparam int unsigned SEL1_OFS = 2;
  localparam int unsigned OP_OFS   = 0;

  // Field order matches the packed context layout, bypass in the MSB.
  typedef struct packed {
    logic       bypass;
    logic [2:0] sel0;
    logic [2:0] sel1;
    logic [1:0] op;
  } cell_cfg_t;

  // Element i occupies bits [9i+8:9i] of the column word.
  typedef cell_cfg_t [NUM_CELLS-1:0] col_cfg_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SHF_PASS = 2'b00,
    SHF_SLL  = 2'b01,
    SHF_SRL  = 2'b10,
    SHF_SRA  = 2'b11
  } shf_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/clb_ctx_mem.sv
// Context register file: one synchronous write port, one asynchronous read port.
module clb_ctx_mem
  import clb_pkg::*;
#(
  parameter int unsigned NCTX  = 8,
  parameter int unsigned CTX_W = 3
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [CTX_W-1:0]     i_wr_addr,
  input  logic [COL_CFG_W-1:0] i_wr_data,
  input  logic [CTX_W-1:0]     i_rd_addr,
  output logic [COL_CFG_W-1:0] o_rd_data
);

  // Contents survive reset so a column can be re-run after a reset.
  logic [COL_CFG_W-1:0] r_mem [NCTX];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/clb_column_sequencer.sv
// Replays a run of stored contexts onto the control inputs of one CLB column.
module clb_column_sequencer
  import clb_pkg::*;
#(
  parameter int unsigned NCTX  = 8,
  parameter int unsigned CTX_W = 3,
  parameter int unsigned LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr_en,
  input  logic [CTX_W-1:0]     cfg_wr_addr,
  input  logic [COL_CFG_W-1:0] cfg_wr_data,
  output logic                 cfg_wr_ready,
  input  logic                 start,
  input  logic [CTX_W-1:0]     start_ctx,
  input  logic [LEN_W-1:0]     run_len,
  input  logic                 stall,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  output logic [3:0]           bypass,
  output logic [2:0]           sel0_0,
  output logic [2:0]           sel1_0,
  output logic [2:0]           sel0_1,
  output logic [2:0]           sel1_1,
  output logic [2:0]           sel0_2,
  output logic [2:0]           sel1_2,
  output logic [2:0]           sel0_3,
  output logic [2:0]           sel1_3,
  output logic [1:0]           selOp0,
  output logic [1:0]           selOp1,
  output logic [1:0]           selOp2,
  output logic [1:0]           selOp3
);

  state_e               r_state, w_state_nxt;
  logic [CTX_W-1:0]     r_ptr, w_ptr_nxt;
  logic [LEN_W-1:0]     r_rem, w_rem_nxt;
  col_cfg_t             r_cfg, w_cfg_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_busy, r_done, r_ready;
  logic                 w_wr_en;
  logic [COL_CFG_W-1:0] w_rd_data;

  assign w_wr_en = cfg_wr_en && r_ready;

  clb_ctx_mem #(
    .NCTX  (NCTX),
    .CTX_W (CTX_W)
  ) u_ctx_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (cfg_wr_addr),
    .i_wr_data (cfg_wr_data),
    .i_rd_addr (r_ptr),
    .o_rd_data (w_rd_data)
  );

  // State and all output/config registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_rem   <= '0;
      r_cfg   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_rem   <= w_rem_nxt;
      r_cfg   <= w_cfg_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
      r_ready <= (w_state_nxt == IDLE);
    end
  end

  // Next-state, issue and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    w_cfg_nxt   = r_cfg;
    w_valid_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_cfg_nxt = '0;
        if (start) begin
          if (run_len != '0) begin
            w_ptr_nxt   = start_ctx;
            w_rem_nxt   = run_len;
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      RUN: begin
        // Abort outranks both stall and issue.
        if (abort) begin
          w_state_nxt = DONE;
        end else if (!stall) begin
          w_cfg_nxt   = w_rd_data;
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = CTX_W'(r_ptr + CTX_W'(1));
          w_rem_nxt   = LEN_W'(r_rem - LEN_W'(1));
          if (r_rem == LEN_W'(1)) w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_cfg_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_cfg_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign cfg_wr_ready = r_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign out_valid    = r_valid;

  assign bypass = {r_cfg[3].bypass, r_cfg[2].bypass, r_cfg[1].bypass, r_cfg[0].bypass};
  assign sel0_0 = r_cfg[0].sel0;
  assign sel1_0 = r_cfg[0].sel1;
  assign sel0_1 = r_cfg[1].sel0;
  assign sel1_1 = r_cfg[1].sel1;
  assign sel0_2 = r_cfg[2].sel0;
  assign sel1_2 = r_cfg[2].sel1;
  assign sel0_3 = r_cfg[3].sel0;
  assign sel1_3 = r_cfg[3].sel1;
  assign selOp0 = r_cfg[0].op;
  assign selOp1 = r_cfg[1].op;
  assign selOp2 = r_cfg[2].op;
  assign selOp3 = r_cfg[3].op;

endmodule

// File: tb/tb_clb_column_sequencer.sv
// Self-checking bench for clb_column_sequencer: directed table, hand sequences, random runs.
module tb_clb_column_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cfg_wr_en;
  logic [2:0]  cfg_wr_addr;
  logic [35:0] cfg_wr_data;
  logic        cfg_wr_ready;
  logic        start;
  logic [2:0]  start_ctx;
  logic [7:0]  run_len;
  logic        stall;
  logic        abort;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [3:0]  bypass;
  logic [2:0]  sel0_0, sel1_0, sel0_1, sel1_1, sel0_2, sel1_2, sel0_3, sel1_3;
  logic [1:0]  selOp0, selOp1, selOp2, selOp3;

  clb_column_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_wr_ready (cfg_wr_ready),
    .start        (start),
    .start_ctx    (start_ctx),
    .run_len      (run_len),
    .stall        (stall),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .out_valid    (out_valid),
    .bypass       (bypass),
    .sel0_0       (sel0_0),
    .sel1_0       (sel1_0),
    .sel0_1       (sel0_1),
    .sel1_1       (sel1_1),
    .sel0_2       (sel0_2),
    .sel1_2       (sel1_2),
    .sel0_3       (sel0_3),
    .sel1_3       (sel1_3),
    .selOp0       (selOp0),
    .selOp1       (selOp1),
    .selOp2       (selOp2),
    .selOp3       (selOp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [35:0] mem_m [8];

  typedef struct {
    int          ctx;
    int          len;
    logic [63:0] pat;
    int          ab;
    int          exp_n;
    int          exp_low;
    bit          exp_dv;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Column word rebuilt from the output ports using the documented bit layout.
  function automatic logic [35:0] out_word();
    return {bypass[3], sel0_3, sel1_3, selOp3,
            bypass[2], sel0_2, sel1_2, selOp2,
            bypass[1], sel0_1, sel1_1, selOp1,
            bypass[0], sel0_0, sel1_0, selOp0};
  endfunction

  task automatic wr(input int a, input logic [35:0] d);
    cfg_wr_en   = 1'b1;
    cfg_wr_addr = 3'(a);
    cfg_wr_data = d;
    abort       = 1'($urandom_range(0, 1));
    step();
    cfg_wr_en = 1'b0;
    abort     = 1'b0;
    mem_m[a]  = d;
  endtask

  // Reference: count of issues, RUN cycles and whether the last issue lands on DONE entry.
  task automatic model(input int len, input logic [63:0] pat, input int ab,
                       output int n, output int low, output bit dv);
    int rc;
    n  = 0;
    rc = 0;
    if (len != 0) begin
      for (int k = 0; k < 200; k++) begin
        rc++;
        if (k == ab) break;
        if (!(k < 64 && pat[k])) begin
          n++;
          if (n == len) break;
        end
      end
    end
    low = rc + 1;
    dv  = (len != 0) && (n == len);
  endtask

  task automatic run(input int ctx, input int len, input logic [63:0] pat, input int ab,
                     input int exp_n, input int exp_low, input bit exp_dv,
                     input bit wr_same, input logic [35:0] wdata, input bit rnd_wr);
    logic [35:0] expq [$];
    int nv, nlow, ndone, cyc;
    bit seen, dv;
    if (wr_same) mem_m[ctx % 8] = wdata;
    for (int i = 0; i < exp_n; i++) expq.push_back(mem_m[(ctx + i) % 8]);
    start       = 1'b1;
    start_ctx   = 3'(ctx);
    run_len     = 8'(len);
    cfg_wr_en   = wr_same;
    cfg_wr_addr = 3'(ctx);
    cfg_wr_data = wdata;
    step();
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    nv = 0; nlow = 0; ndone = 0; cyc = 0; seen = 0; dv = 0;
    while (!seen && cyc < 200) begin
      if (!cfg_wr_ready) nlow++;
      if (done) begin
        ndone++;
        seen = 1;
        dv   = out_valid;
        chk("done_busy", 64'(busy), 64'd1);
      end
      if (out_valid) begin
        if (nv < exp_n) chk("issue_word", 64'(out_word()), 64'(expq[nv]));
        nv++;
      end else if (!seen && nv == 0) begin
        chk("pre_issue_zero", 64'(out_word()), 64'd0);
      end else if (!seen && nv <= exp_n) begin
        chk("stall_hold", 64'(out_word()), 64'(expq[nv-1]));
      end
      if (seen) break;
      stall = (cyc < 64) ? pat[cyc] : 1'b0;
      abort = (cyc == ab);
      if (rnd_wr) begin
        cfg_wr_en   = 1'($urandom_range(0, 1));
        cfg_wr_addr = 3'($urandom_range(0, 7));
        cfg_wr_data = {4'($urandom), 32'($urandom)};
      end
      step();
      cyc++;
    end
    stall = 1'b0; abort = 1'b0; cfg_wr_en = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("valid_count", 64'(nv), 64'(exp_n));
    chk("done_count", 64'(ndone), 64'd1);
    chk("done_valid", 64'(dv), 64'(exp_dv));
    chk("ready_low", 64'(nlow), 64'(exp_low));
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_word", 64'(out_word()), 64'd0);
    chk("idle_ready", 64'(cfg_wr_ready), 64'd1);
  endtask

  initial begin
    int n, low;
    bit dv;
    int ctx, len, ab;
    logic [63:0] pat;

    tbl[0] = '{ctx: 0, len: 4,  pat: 64'h0,  ab: -1, exp_n: 4, exp_low: 5,  exp_dv: 1};
    tbl[1] = '{ctx: 6, len: 4,  pat: 64'h0,  ab: -1, exp_n: 4, exp_low: 5,  exp_dv: 1};
    tbl[2] = '{ctx: 2, len: 3,  pat: 64'h6,  ab: -1, exp_n: 3, exp_low: 6,  exp_dv: 1};
    tbl[3] = '{ctx: 0, len: 10, pat: 64'h0,  ab: 2,  exp_n: 2, exp_low: 4,  exp_dv: 0};
    tbl[4] = '{ctx: 5, len: 0,  pat: 64'h0,  ab: -1, exp_n: 0, exp_low: 1,  exp_dv: 0};
    tbl[5] = '{ctx: 7, len: 9,  pat: 64'h0,  ab: -1, exp_n: 9, exp_low: 10, exp_dv: 1};
    tbl[6] = '{ctx: 4, len: 5,  pat: 64'h1,  ab: 0,  exp_n: 0, exp_low: 2,  exp_dv: 0};
    tbl[7] = '{ctx: 1, len: 2,  pat: 64'h2,  ab: -1, exp_n: 2, exp_low: 4,  exp_dv: 1};

    rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    start = 1'b0; start_ctx = '0; run_len = '0; stall = 1'b0; abort = 1'b0;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_word", 64'(out_word()), 64'd0);
    chk("rst_ready", 64'(cfg_wr_ready), 64'd1);
    rst_n = 1'b1;

    wr(0, 36'h1_0000_0001);
    wr(1, 36'h2_0000_0002);
    wr(2, 36'h3_0000_0003);
    wr(3, 36'h4_0000_0004);
    for (int i = 4; i < 8; i++) wr(i, {4'($urandom), 32'($urandom)});

    // Single-context run: field decode of ctx0 and done coinciding with the issue.
    start = 1'b1; start_ctx = 3'd0; run_len = 8'd1;
    step();
    start = 1'b0;
    chk("first_lat_valid", 64'(out_valid), 64'd0);
    step();
    chk("dec_valid", 64'(out_valid), 64'd1);
    chk("dec_selOp0", 64'(selOp0), 64'd1);
    chk("dec_sel0_3", 64'(sel0_3), 64'd1);
    chk("dec_bypass", 64'(bypass), 64'd0);
    chk("dec_done", 64'(done), 64'd1);
    step();
    chk("dec_idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++)
      run(tbl[i].ctx, tbl[i].len, tbl[i].pat, tbl[i].ab, tbl[i].exp_n,
          tbl[i].exp_low, tbl[i].exp_dv, 1'b0, 36'h0, 1'b1);

    // Write and start to the same address in one IDLE cycle.
    run(3, 1, 64'h0, -1, 1, 2, 1'b1, 1'b1, 36'hA_BCDE_F012, 1'b0);

    // Reset in the middle of a run with five contexts still pending.
    start = 1'b1; start_ctx = 3'd0; run_len = 8'd10;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_valid", 64'(out_valid), 64'd1);
    chk("mid_word", 64'(out_word()), 64'(mem_m[4]));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_word", 64'(out_word()), 64'd0);
    chk("mrst_ready", 64'(cfg_wr_ready), 64'd1);
    run(0, 8, 64'h0, -1, 8, 9, 1'b1, 1'b0, 36'h0, 1'b0);

    // Randomised runs against the reference model.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 7), {4'($urandom), 32'($urandom)});
      ctx = $urandom_range(0, 7);
      len = $urandom_range(0, 12);
      pat = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)};
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : -1;
      model(len, pat, ab, n, low, dv);
      run(ctx, len, pat, ab, n, low, dv, 1'($urandom_range(0, 1)), {4'($urandom), 32'($urandom)}, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
